// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: one AXI read per accepted next-PC, result handed to decode
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] npc_i,
    input  logic            npc_valid_i,
    output logic            npc_ready_o,
    output logic [XLEN-1:0] axi_AR_ADDR,
    output logic            axi_AR_VALID,
    input  logic            axi_AR_READY,
    input  logic [XLEN-1:0] axi_R_DATA,
    input  logic            axi_R_VALID,
    output logic            axi_R_READY,
    output logic            idu_valid_o,
    input  logic            idu_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_AR   = 2'd0,
        S_R    = 2'd1,
        S_OUT  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     inst_r;
    logic [XLEN-1:0] fetch_cnt_r;

    logic ar_fire;
    logic r_fire;
    logic idu_fire;
    logic npc_fire;

    // Handshakes qualified by state only, so every output stays a pure state decode
    assign ar_fire  = (state == S_AR)   && axi_AR_READY;
    assign r_fire   = (state == S_R)    && axi_R_VALID;
    assign idu_fire = (state == S_OUT)  && idu_ready_i;
    assign npc_fire = (state == S_WAIT) && npc_valid_i;

    always_comb begin
        state_nxt = state;
        case (state)
            S_AR:    if (axi_AR_READY) state_nxt = S_R;
            S_R:     if (axi_R_VALID)  state_nxt = S_OUT;
            S_OUT:   if (idu_ready_i)  state_nxt = S_WAIT;
            S_WAIT:  if (npc_valid_i)  state_nxt = S_AR;
            default: state_nxt = S_AR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_AR;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r        <= RESET_PC[XLEN-1:0];
            inst_r      <= '0;
            fetch_cnt_r <= '0;
        end else begin
            if (npc_fire) begin
                pc_r <= npc_i;
            end
            // Word select within the 8-byte beat; pc_r[1:0] is intentionally not checked
            if (r_fire) begin
                inst_r <= pc_r[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];
            end
            if (idu_fire) begin
                fetch_cnt_r <= fetch_cnt_r + {{(XLEN-1){1'b0}}, 1'b1};
            end
        end
    end

    // AR_VALID is masked during reset because the reset state itself is S_AR
    assign axi_AR_VALID = (state == S_AR) && !rst;
    assign axi_AR_ADDR  = {pc_r[XLEN-1:3], 3'b000};
    assign axi_R_READY  = (state == S_R);
    assign idu_valid_o  = (state == S_OUT);
    assign npc_ready_o  = (state == S_WAIT);
    assign pc_o         = pc_r;
    assign inst_o       = inst_r;
    assign fetch_cnt_o  = fetch_cnt_r;

    logic unused_fire;
    assign unused_fire = ar_fire;

endmodule
